// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding, width limit and counter sizing helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full-adder cell, purely combinational.
// Latency: zero cycles; no flow control.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder reusing one full-adder cell, LSB first.
// Latency WIDTH+1 cycles from accepted start to done; start ignored unless idle.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    logic             last_bit;

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // The partial sum only needs WIDTH-1 bits: the final bit comes straight
    // from the cell on the completing edge.
    if (WIDTH > 1) begin : g_sum_sr
        logic [WIDTH-2:0] sum_sr;

        assign sum_shift = {fa_sum, sum_sr};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_sr <= '0;
            end else if (state == RUN) begin
                sum_sr <= sum_shift[WIDTH-1:1];
            end
        end
    end else begin : g_no_sum_sr
        assign sum_shift = fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= sum_shift;
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Reference results come from plain integer addition of the applied operands.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start8, cin8, busy8, done8, cout8;
    logic [W-1:0] a8, b8, sum8;
    logic         start1, cin1, busy1, done1, cout1;
    logic [0:0]   a1, b1, sum1;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] last_sum8 = '0;
    logic         last_cout8 = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // One addition on the 8-bit instance; optionally disturbs inputs while busy.
    task automatic run8(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input bit scramble, input string name);
        logic [W:0] expv;
        int         cyc, busy_cyc;
        bit         stable_ok;
        expv = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1; busy_cyc = 0; stable_ok = 1'b1;
        while (!done8 && cyc < 40) begin
            if (busy8) busy_cyc++;
            if (sum8 !== last_sum8 || cout8 !== last_cout8) stable_ok = 1'b0;
            if (scramble) begin
                a8 = W'($urandom); b8 = W'($urandom);
                cin8 = 1'($urandom); start8 = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        checks++;
        if (cyc !== W + 1)
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, W + 1);
        if (cyc !== W + 1) errors++;
        checks++;
        if (busy_cyc !== W) begin
            $display("FAIL %s busy: got %0d cycles, expected %0d", name, busy_cyc, W);
            errors++;
        end
        checks++;
        if (!stable_ok) begin
            $display("FAIL %s hold: sum/cout changed before completion, expected %h/%b", name, last_sum8, last_cout8);
            errors++;
        end
        checks++;
        if ({cout8, sum8} !== expv) begin
            $display("FAIL %s result: got cout=%b sum=%h, expected cout=%b sum=%h", name, cout8, sum8, expv[W], expv[W-1:0]);
            errors++;
        end
        last_sum8 = expv[W-1:0];
        last_cout8 = expv[W];
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            $display("FAIL %s done_pulse: done still %b one cycle later, expected 0", name, done8);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, cout8, sum8} !== '0 || {busy1, done1, cout1, sum1} !== '0) begin
            $display("FAIL reset_state: got w8 %b%b%b %h w1 %b%b%b%b, expected all zero",
                     busy8, done8, cout8, sum8, busy1, done1, cout1, sum1);
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run8(8'h05, 8'h03, 1'b0, 1'b0, "add_05_03");
        run8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");
    endtask

    task automatic test_back_to_back();
        int         t;
        int         n;
        int         tdone[2];
        logic [W:0] got[2];
        n = 0;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        t = 0;
        while (n < 2 && t < 40) begin
            @(negedge clk);
            t++;
            if (t == 1) begin a8 = 8'h80; b8 = 8'h80; end
            if (done8) begin
                tdone[n] = t;
                got[n] = {cout8, sum8};
                n++;
            end
        end
        start8 = 1'b0;
        checks++;
        if (n !== 2 || tdone[0] !== 9 || tdone[1] !== 19) begin
            $display("FAIL b2b_timing: got %0d dones at %0d/%0d, expected 2 at 9/19", n, tdone[0], tdone[1]);
            errors++;
        end
        checks++;
        if (got[0] !== 9'h046 || got[1] !== 9'h100) begin
            $display("FAIL b2b_results: got %h/%h, expected 046/100", got[0], got[1]);
            errors++;
        end
        last_sum8 = 8'h00;
        last_cout8 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, cout8, sum8} !== '0) begin
            $display("FAIL abort_outputs: got busy=%b done=%b cout=%b sum=%h, expected all zero", busy8, done8, cout8, sum8);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        checks++;
        if (seen !== 0) begin
            $display("FAIL abort_no_done: got %0d active cycles after abort, expected 0", seen);
            errors++;
        end
        last_sum8 = '0;
        last_cout8 = 1'b0;
        run8(8'h01, 8'h01, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            run8(W'($urandom), W'($urandom), 1'($urandom), bit'(i % 2), "random");
    endtask

    task automatic test_width1();
        int cyc;
        int expv;
        for (int i = 0; i < 8; i++) begin
            expv = (i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1);
            @(negedge clk);
            a1 = 1'(i); b1 = 1'(i >> 1); cin1 = 1'(i >> 2); start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            cyc = 1;
            while (!done1 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc !== 2 || {cout1, sum1} !== 2'(expv)) begin
                $display("FAIL w1_case%0d: got cyc=%0d cout=%b sum=%b, expected cyc=2 cout=%b sum=%b",
                         i, cyc, cout1, sum1, expv[1], expv[0]);
                errors++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around a single 1-bit full-adder cell plus a carry flip-flop. It accepts two parallel operands and a carry-in on a start strobe, then processes one bit per clock, LSB first. It presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential stage that directly drives the lab's 1-bit full-adder cell, replacing a WIDTH-cell ripple chain with one reused cell.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A; captured when start is accepted
b  input  WIDTH  operand B; captured when start is accepted
cin  input  1  carry-in; captured when start is accepted
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  result; holds its value until the next completion
cout  output  1  final carry-out; holds with sum

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry flop and bit counter cleared. Reset takes effect mid-operation and aborts the addition; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: a, b → operand shift regs; cin → carry flop; counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Full-adder cell evaluates a_sr[0], b_sr[0], carry.
  - Sum bit shifts into the MSB of the sum shift reg (right shift); a_sr and b_sr shift right.
  - carry <= cell cout; counter += 1.
  - On the edge where counter==WIDTH-1: the completed sum shift reg copies to sum, the cell cout copies to cout, and the state goes to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency: start sampled at edge E0; RUN occupies WIDTH cycles; done is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- Throughput: one addition per WIDTH+2 cycles when start is held high.
- start while busy=1 or in DONE is ignored. Operand changes after acceptance have no effect.
- sum/cout change only at completion. They are stable from done until the next completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned.
- Counter width is max(1, $clog2(WIDTH)). For WIDTH=1, RUN lasts one cycle.
- No X propagation: all registers have reset values.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - constant MAX_WIDTH=32.
- Sub-module full_adder_cell: purely combinational; inputs a, b, cin; outputs sum = a^b^cin and cout = majority(a,b,cin). Instantiated once.
- Everything else (FSM, shift regs, counter, carry flop, output regs) lives in serial_adder.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, cin=0, start pulse → busy high 8 cycles; done pulse 9 cycles after the start edge; sum=0x08, cout=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
3. Hold start=1 continuously with operand pairs (0x12+0x34, then 0x80+0x80) → done every 10 cycles; sums 0x46/cout=0, then 0x00/cout=1. start pulses during RUN/DONE do not restart the operation.
4. Start 0xAA+0x55, assert rst_n low after 4 RUN cycles → outputs immediately 0, state IDLE, no done. A new start 0x01+0x01 completes with sum=0x02.
5. Change a/b during RUN → result reflects the captured values only; sum/cout unchanged between completions.
6. WIDTH=1, all 8 combinations of a, b, cin → sum/cout match the full-adder truth table; done 2 cycles after start.
